// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream multiplexer with packet locking.
// A granted channel keeps the output until it delivers its last beat; between
// packets the next channel is chosen by the arbiter. A single output register
// gives one cycle of latency at full throughput.
// Configuration macro: STREAM_MUX_RR_EN
//   defined   -> round-robin arbitration starting at rr_ptr
//   undefined -> fixed priority, lowest-index valid channel wins
module stream_mux_rr #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [$clog2(CHANNELS)-1:0] out_sel,
    input  logic                      out_ready
);

    localparam int SEL_W = $clog2(CHANNELS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   lock_idx_q, lock_idx_d;
`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic [SEL_W-1:0]   grant_s;
    logic               grant_valid_s;
    logic               load_s;
    logic               xfer_s;
    logic               sel_last_s;
    logic [WIDTH-1:0]   sel_data_s;

    // Output register may take a new beat when empty or being drained this cycle.
    assign load_s = !out_valid || out_ready;

    // Grant selection: locked channel holds the grant, otherwise arbitrate.
    always_comb begin
        int sum;
        grant_s       = '0;
        grant_valid_s = 1'b0;
        sum           = 0;
        if (state_q == ST_LOCKED) begin
            grant_s       = lock_idx_q;
            grant_valid_s = in_valid[lock_idx_q];
        end else begin
            // Scan from the farthest candidate down so the nearest valid one wins.
            for (int off = CHANNELS - 1; off >= 0; off--) begin
`ifdef STREAM_MUX_RR_EN
                sum = int'(rr_ptr_q) + off;
                if (sum >= CHANNELS) begin
                    sum = sum - CHANNELS;
                end else begin
                    sum = sum;
                end
`else
                sum = off;
`endif
                if (in_valid[SEL_W'(sum)]) begin
                    grant_s       = SEL_W'(sum);
                    grant_valid_s = 1'b1;
                end else begin
                    grant_s       = grant_s;
                    grant_valid_s = grant_valid_s;
                end
            end
        end
    end

    assign xfer_s     = rst_n && load_s && grant_valid_s;
    assign sel_last_s = in_last[grant_s];
    assign sel_data_s = in_data[int'(grant_s)*WIDTH +: WIDTH];

    // One-hot accept toward the granted channel, forced low during reset.
    always_comb begin
        in_ready = '0;
        if (xfer_s) begin
            in_ready[grant_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Next-state logic for the packet lock and the arbitration pointer.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
`ifdef STREAM_MUX_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer_s && !sel_last_s) begin
                    state_d    = ST_LOCKED;
                    lock_idx_d = grant_s;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && sel_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_idx_d = '0;
            end
        endcase
`ifdef STREAM_MUX_RR_EN
        // Pointer moves past the channel that just finished a packet.
        if (xfer_s && sel_last_s) begin
            rr_ptr_d = (grant_s == SEL_W'(CHANNELS - 1)) ? '0 : grant_s + SEL_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`endif
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_idx_q <= '0;
`ifdef STREAM_MUX_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
`ifdef STREAM_MUX_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    // Output register: load on transfer, drop valid on drain, hold on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (load_s) begin
            if (xfer_s) begin
                out_valid <= 1'b1;
                out_data  <= sel_data_s;
                out_last  <= sel_last_s;
                out_sel   <= grant_s;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (4-channel and 3-channel instances).
module tb_stream_mux_rr;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  chan_word [4];
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_last;
    logic [1:0]   out_sel;
    logic         out_ready;

    logic         rst3_n;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_last3;
    logic [2:0]   in_ready3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_last3;
    logic [1:0]   out_sel3;
    logic         out_ready3;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries: {sel[1:0], last, data[31:0]}
    logic [34:0] sb [$];

    // Reference model state
    bit m_locked;
    int m_lock;
    int m_ptr;
    bit m_ovalid;

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = chan_word[c];
    end

    stream_mux_rr #(.WIDTH(32), .CHANNELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(32), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_last(out_last3), .out_sel(out_sel3),
        .out_ready(out_ready3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int ptr);
`ifdef STREAM_MUX_RR_EN
        for (int off = 0; off < 4; off++) begin
            if (v[(ptr + off) % 4]) return (ptr + off) % 4;
        end
`else
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
`endif
        return 0;
    endfunction

    // Drive one cycle of stimulus, check in_ready against the model, push expected output.
    task automatic beat(input logic [3:0] v, input logic [3:0] l, input logic ordy);
        bit ld;
        bit gv;
        int g;
        logic [3:0] exp_rdy;
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        #1;
        ld = !m_ovalid || ordy;
        if (m_locked) begin
            g  = m_lock;
            gv = v[g];
        end else begin
            g  = pick(v, m_ptr);
            gv = |v;
        end
        exp_rdy = (ld && gv) ? (4'b0001 << g) : 4'b0000;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (ld && gv) begin
            sb.push_back({2'(g), l[g], chan_word[g]});
            m_ovalid = 1'b1;
            if (l[g]) begin
                m_locked = 1'b0;
                m_ptr    = (g == 3) ? 0 : g + 1;
            end else if (!m_locked) begin
                m_locked = 1'b1;
                m_lock   = g;
            end
        end else if (ld) begin
            m_ovalid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every output transfer is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out_data), 64'h0);
                check("unexpected_output_valid", 64'(out_valid), 64'h0);
            end else begin
                logic [34:0] e;
                e = sb.pop_front();
                check("out_sel",  64'(out_sel),  64'(e[34:33]));
                check("out_last", 64'(out_last), 64'(e[32]));
                check("out_data", 64'(out_data), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp3 [4];
        for (int c = 0; c < 4; c++) chan_word[c] = {4'hA, 4'(c), 16'h0000, 8'h00};
        in_data3   = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        in_valid3  = 3'b000;
        in_last3   = 3'b111;
        out_ready3 = 1'b1;
        rst3_n     = 1'b0;

        // Reset with every channel requesting
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data",  64'(out_data),  64'h0);
        check("rst_out_sel",   64'(out_sel),   64'h0);
        check("rst_out_last",  64'(out_last),  64'h0);
        m_locked = 1'b0; m_lock = 0; m_ptr = 0; m_ovalid = 1'b0;
        rst_n = 1'b1;

        // All channels valid, single-beat packets
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 4; c++) chan_word[c] = {4'hA, 4'(c), 16'h0000, 8'(i)};
            beat(4'hF, 4'hF, 1'b1);
        end
        beat(4'h0, 4'h0, 1'b1);
        beat(4'h0, 4'h0, 1'b1);

        // Channel 2 three-beat packet, channel 0 joins mid-packet
        for (int c = 0; c < 4; c++) chan_word[c] = {4'hB, 4'(c), 16'h0000, 8'h01};
        beat(4'b0100, 4'b0000, 1'b1);
        chan_word[2] = 32'hB200_0002;
        beat(4'b0101, 4'b0001, 1'b1);
        chan_word[2] = 32'hB200_0003;
        beat(4'b0101, 4'b0101, 1'b1);
        beat(4'b1001, 4'b1001, 1'b1);
        beat(4'h0, 4'h0, 1'b1);
        beat(4'h0, 4'h0, 1'b1);

        // Backpressure: hold a loaded beat for five cycles, then drain with no bubble
        chan_word[1] = 32'hDEAD_BEEF;
        beat(4'b0010, 4'b0010, 1'b1);
        chan_word[1] = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            beat(4'b0010, 4'b0010, 1'b0);
            check("bp_hold_data",  64'(out_data),  64'hDEAD_BEEF);
            check("bp_hold_valid", 64'(out_valid), 64'h1);
        end
        beat(4'b0010, 4'b0010, 1'b1);
        check("bp_nobubble_valid", 64'(out_valid), 64'h1);
        check("bp_nobubble_data",  64'(out_data),  64'h1234_5678);
        beat(4'h0, 4'h0, 1'b1);
        beat(4'h0, 4'h0, 1'b1);

        // Reset in the middle of a four-beat packet on channel 1
        chan_word[1] = 32'hC100_0001;
        beat(4'b0010, 4'b0000, 1'b1);
        rst_n    = 1'b0;
        in_valid = 4'b0010;
        in_last  = 4'b0000;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'h0);
        sb.delete();
        m_locked = 1'b0; m_lock = 0; m_ptr = 0; m_ovalid = 1'b0;
        rst_n = 1'b1;
        chan_word[3] = 32'hC300_0003;
        beat(4'b1000, 4'b1000, 1'b1);
        check("midrst_sel3",   64'(out_sel),  64'h3);
        check("midrst_data3",  64'(out_data), 64'hC300_0003);
        beat(4'h0, 4'h0, 1'b1);
        beat(4'h0, 4'h0, 1'b1);
        check("sb_empty", 64'(sb.size()), 64'h0);

        // Three-channel instance: wrap without reaching index 3
`ifdef STREAM_MUX_RR_EN
        exp3[0] = 2'd0; exp3[1] = 2'd1; exp3[2] = 2'd2; exp3[3] = 2'd0;
`else
        exp3[0] = 2'd0; exp3[1] = 2'd0; exp3[2] = 2'd0; exp3[3] = 2'd0;
`endif
        in_valid3 = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check("c3_rst_ready", 64'(in_ready3), 64'h0);
        rst3_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("c3_out_sel",   64'(out_sel3),   64'(exp3[i]));
            check("c3_out_valid", 64'(out_valid3), 64'h1);
            check("c3_out_data",  64'(out_data3),  64'({16'h3333, 14'h0, exp3[i]}));
        end
        in_valid3 = 3'b000;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel registered stream multiplexer with valid/ready handshakes, packet locking and round-robin arbitration. It is the successor to the fixed 2:1 combinational select and merges several request sources into one consumer, for example instruction-fetch and data ports onto a shared memory bus. A single output register gives full throughput with one cycle of latency.

## Interface
- `WIDTH`, 32, payload bits per channel.
- `CHANNELS`, 4, number of input channels; legal range 2..16.
- `SEL_W`, derived localparam, $clog2(CHANNELS); not overridable.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_data` input CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` input CHANNELS: per-channel beat valid.
- `in_last` input CHANNELS: per-channel last-beat-of-packet flag.
- `in_ready` output CHANNELS: per-channel accept; combinational.
- `out_data` output WIDTH: registered payload.
- `out_valid` output 1: registered valid.
- `out_last` output 1: registered last flag.
- `out_sel` output SEL_W: index of the source channel for the current output beat.
- `out_ready` input 1: consumer accept.

## Operation
- Transfers:
  - An input beat transfers on channel i when `in_valid[i] && in_ready[i]`.
  - An output beat transfers when `out_valid && out_ready`.
- Output register enable: `load = !out_valid || out_ready`.
- `in_ready[i] = load && grant_valid && (grant == i)`. At most one bit of `in_ready` is high. All bits are 0 while `rst_n == 0`.
- State machine:
  - IDLE, unlocked:
    - `grant` is chosen combinationally among the asserted `in_valid` bits.
    - `grant_valid` is high if any bit is set.
    - An accepted beat with `in_last=1` stays in IDLE. An accepted beat with `in_last=0` moves to LOCKED and latches `grant` into `lock_idx`.
  - LOCKED:
    - `grant = lock_idx` and `grant_valid = in_valid[lock_idx]`.
    - Other channels are starved until channel `lock_idx` delivers a beat with `in_last=1`. The state then returns to IDLE.
    - A valid drop on the locked channel stalls the block. It does not release the lock.
- Arbitration in IDLE (see Configuration): the first valid channel at or after `rr_ptr`, searching upward modulo CHANNELS.
- Pointer update:
  - On acceptance of a last beat from channel g: `rr_ptr <= (g == CHANNELS-1) ? 0 : g+1`. This wraps correctly for CHANNELS values that are not a power of two.
  - `rr_ptr` does not change on non-last beats or idle cycles.
- Output register load: on an input transfer, `out_data <= in_data[grant]`, `out_last <= in_last[grant]`, `out_sel <= grant`, `out_valid <= 1`.
- Output register drain: if `load` is high and there is no input transfer, `out_valid <= 0`. `out_data`, `out_last` and `out_sel` hold their values.
- Consumer stall: if `out_valid && !out_ready`, all output registers hold.
- Reset, while `rst_n == 0` at a clock edge:
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`.
  - State=IDLE, `rr_ptr=0`, `lock_idx=0`.
  - Reset mid-packet discards the lock and any pending output beat.

## Timing
- Latency: an input beat accepted at edge k is presented on `out_*` from edge k until the output transfer.
- Combinational path: in_valid to in_ready, and out_ready to in_ready. There is no combinational path from any input to `out_*`.
- Throughput: one beat per cycle while `out_ready=1` and the granted channel is valid.
- Simultaneous output transfer and new load in the same cycle: the output is replaced with no bubble.
- Simultaneous valid on all channels: exactly one grant per packet. Each channel is served within CHANNELS packets.
- First cycle after reset release: `in_ready` may assert in the same cycle `rst_n` is sampled high.

## Configuration
- Macro: `STREAM_MUX_RR_EN`.
- Defined: round-robin arbitration using `rr_ptr` as described above.
- Undefined: fixed priority, where the lowest-index valid channel wins in IDLE. `rr_ptr` logic is removed. Locking behaviour is unchanged.

## Test plan
- Reset with CHANNELS=4, WIDTH=32: hold rst_n=0 with all in_valid=1. Required: in_ready=4'b0000, out_valid=0, out_data=0, out_sel=0.
- Round-robin with RR_EN defined: all channels valid with single-beat packets (in_last=1) and out_ready=1. Required: out_sel sequence 0,1,2,3,0 on consecutive cycles, and out_data equal to each channel's word.
- Lock: channel 2 sends a 3-beat packet (last on beat 3) while channel 0 stays valid. Required: out_sel=2 for 3 consecutive beats, then 3 or 0 per rr_ptr; channel 0 is never ready during the packet.
- Backpressure: out_ready=0 for 5 cycles with a beat 0xDEADBEEF from channel 1 loaded. Required: out_data and out_valid hold, and in_ready=0. out_ready=1 then gives one transfer and an immediate next load with no bubble.
- Non-power-of-two wrap with CHANNELS=3: single-beat packets on all channels. Required: out_sel 0,1,2,0 and rr_ptr never reaches 3. With the macro undefined, out_sel stays 0 continuously.
- Reset mid-packet: assert rst_n=0 after beat 1 of a 4-beat packet on channel 1. After release, channel 3 alone valid is granted immediately with out_sel=3.
